sample_stream_engine: RTL and testbench
=======================================

# sample_stream_engine

Synthesizable playback/capture engine that replaces the simulation-only sample feeder of the birdsong filter chain. It streams a stored multi-channel sample buffer into the chain at a programmable sample rate with valid/ready handshaking, and records the chain's response into an on-chip capture buffer that can be read back. Playback can be one-shot or looping. Status flags report underruns and capture overflow.

## Interface
- DATA_W, 16: sample width, two's complement.
- N_CH, 1: channels per frame, interleaved in memory as ch0..ch(N_CH-1); valid range 1–8.
- DEPTH, 4096: playback memory words; capture memory also holds DEPTH words; ADDR_W = $clog2(DEPTH).
- RATE_DIV, 2083: clk cycles per frame tick (100 MHz / 48 kHz); must be ≥ 2*N_CH+2.
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-low reset.
- wr_en / wr_addr / wr_data  in  1 / ADDR_W / DATA_W  playback memory write port; ignored while busy.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- stop  in  1  one-cycle pulse; requests abort.
- loop_en  in  1  sampled at start; 1 = wrap to frame 0 after the last frame.
- len  in  ADDR_W  frames to play; sampled at start.
- m_data / m_ch / m_valid  out  DATA_W / 3 / 1  stream to the chain.
- m_ready  in  1  chain accepts.
- s_data / s_valid  in  DATA_W / 1  chain output; no backpressure.
- rd_addr / rd_data  in ADDR_W / out DATA_W  capture readback; 1-cycle latency.
- busy / done / err  out  1  running; one-cycle completion pulse; start rejected (sticky).
- underrun / cap_full  out  1  sticky flags, cleared by the next accepted start.
- cap_count  out  ADDR_W+1  samples captured.

## Operation
- States: IDLE, WAIT_TICK, FETCH, SEND, DONE.
- IDLE: start with 1 ≤ len ≤ DEPTH/N_CH → clear frame/ch/cap pointers, cap_count, underrun and cap_full; set div_cnt=0; go to WAIT_TICK. An out-of-range len leaves the block in IDLE and sets err. A later accepted start clears err.
- Tick: tick = busy && div_cnt==0. When busy, div_cnt counts 0 → RATE_DIV-1 → 0 continuously.
- WAIT_TICK: on tick, present read address frame*N_CH+ch with ch=0, then go to FETCH.
- FETCH: memory data becomes registered into m_data and m_ch=ch; go to SEND.
- SEND: m_valid=1, held with data stable until m_valid && m_ready. Then:
  - ch < N_CH-1: ch++, read the next address, go to FETCH.
  - Otherwise set ch=0 and frame++.
  - frame reaches len with loop_en=0: go to DONE.
  - frame reaches len with loop_en=1: set frame=0 and go to WAIT_TICK.
  - Not at the last frame: go to WAIT_TICK.
- Tick while not in WAIT_TICK: the tick is dropped and underrun is set. The frame is not skipped and is sent on the next tick.
- DONE: done=1 for one cycle, then go to IDLE.
- stop: latched as pending.
  - Honored in WAIT_TICK or FETCH immediately.
  - In SEND, honored after the handshake completes; m_valid never drops without a transfer.
  - Honoring a stop goes to DONE.
- Capture, while busy: each s_valid writes s_data at cap_count, then cap_count++. When cap_count==DEPTH, further samples are dropped and cap_full is set.
- The capture buffer keeps its contents through IDLE and after stop. The read port always works.
- Playback memory has no reset. Capture memory has no reset.

## Timing
- Reset values: state=IDLE, m_valid=0, m_data=0, m_ch=0, busy=0, done=0, err=0, underrun=0, cap_full=0, cap_count=0, div_cnt=0, stop pending cleared.
- A reset mid-playback aborts within one cycle with no done pulse.
- Start sampled at edge E0 → busy=1 and WAIT_TICK at E1 (tick in that cycle) → FETCH at E2 → m_valid=1 at E3.
- Later frames: m_valid rises 2 cycles after their tick.
- With m_ready held high, channel k of a frame is transferred at tick+2+2k.
- done rises the cycle after the final handshake; busy falls together with done.
- Simultaneous start and stop in IDLE: start is taken, stop is ignored.
- Simultaneous s_valid and start: the sample is not captured.
- wr_en while busy: no write.
- cap_count saturates at DEPTH.

## Test plan
- DEPTH=16, N_CH=2, RATE_DIV=8, mem[i]=0x0100+i, len=3, loop_en=0, m_ready=1 → 6 transfers: 0x0100/ch0, 0x0101/ch1 … 0x0105/ch1. First m_valid 3 cycles after start; frames 8 cycles apart; done pulses once; busy falls.
- Same setup with loop_en=1, stop asserted after 8 transfers → sequence wraps 0x0105 → 0x0100; stop lands mid-SEND and the pending handshake completes; done pulses; no further m_valid.
- m_ready held low for 20 cycles on frame 0 ch1 → m_data=0x0101 stable throughout; underrun=1; frame 1 is sent on a later tick with no sample skipped.
- Loopback s_data=m_data, s_valid=handshake, len=8 (16 samples) → cap_count=16; rd_addr 0..15 returns 0x0100..0x010F one cycle later; cap_full=0.
- Drive s_valid constantly for 40 cycles while busy → cap_count=16, cap_full=1, entries 0..15 unchanged afterwards.
- Start with len=0 and with len=9 → err=1, busy stays 0. Reset mid-SEND → m_valid=0 and all flags 0 next cycle.

Source files
------------

// File: rtl/sample_stream_engine.sv
// sample_stream_engine
//   Streams a stored, channel-interleaved sample buffer into a downstream chain at a fixed
//   frame rate (valid/ready), and records the chain's response into a capture buffer.
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data     playback memory write port (ignored while busy)
//   start/stop/loop_en/len    run control; loop_en and len are sampled at start
//   m_data/m_ch/m_valid/m_ready   outbound sample stream
//   s_data/s_valid            chain response, captured while busy
//   rd_addr/rd_data           capture readback, one-cycle latency
//   busy/done/err             running, completion pulse, sticky start-rejected flag
//   underrun/cap_full         sticky flags, cleared by the next accepted start
//   cap_count                 number of captured samples (saturates at DEPTH)
module sample_stream_engine #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned N_CH     = 1,
   parameter int unsigned DEPTH    = 4096,
   parameter int unsigned RATE_DIV = 2083,
   localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [ADDR_W-1:0] len,
   output logic [DATA_W-1:0] m_data,
   output logic [2:0]        m_ch,
   output logic              m_valid,
   input  logic              m_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              underrun,
   output logic              cap_full,
   output logic [ADDR_W:0]   cap_count
);

   localparam int unsigned DIV_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
   localparam logic [DIV_W-1:0] DivLast = DIV_W'(RATE_DIV - 1);
   localparam logic [ADDR_W:0]  NchL    = (ADDR_W + 1)'(N_CH);
   localparam logic [ADDR_W:0]  MaxLen  = (ADDR_W + 1)'(DEPTH / N_CH);
   localparam logic [ADDR_W:0]  CapMax  = (ADDR_W + 1)'(DEPTH);
   localparam logic [2:0]       LastCh  = 3'(N_CH - 1);

   typedef enum logic [2:0] {StIdle, StWaitTick, StFetch, StSend, StDone} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W:0]     frame_q, frame_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [2:0]          ch_q, ch_d;
   logic                loop_q, loop_d;
   logic                stop_pend_q, stop_pend_d;
   logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
   logic [DATA_W-1:0]   m_data_q, m_data_d;
   logic [2:0]          m_ch_q, m_ch_d;
   logic                err_q, err_d;
   logic                underrun_q, underrun_d;
   logic                cap_full_q, cap_full_d;
   logic [ADDR_W:0]     cap_count_q, cap_count_d;

   logic                busy_int, tick, stop_req, len_ok, cap_we;
   logic [ADDR_W:0]     frame_inc;
   logic [2:0]          rd_ch;
   logic [ADDR_W-1:0]   pb_raddr;
   logic [DATA_W-1:0]   pb_rd_q;
   logic [DATA_W-1:0]   rd_data_q;

   logic [DATA_W-1:0]   pb_mem  [DEPTH];
   logic [DATA_W-1:0]   cap_mem [DEPTH];

   assign busy_int  = (state_q == StWaitTick) || (state_q == StFetch) || (state_q == StSend);
   assign tick      = busy_int && (div_cnt_q == '0);
   assign stop_req  = stop || stop_pend_q;
   assign len_ok    = (len != '0) && ({1'b0, len} <= MaxLen);
   assign frame_inc = frame_q + 1'b1;

   // In SEND the next channel's word is prefetched so FETCH can register it into m_data.
   assign rd_ch    = (state_q == StSend) ? ch_q + 3'd1 : 3'd0;
   assign pb_raddr = ADDR_W'(frame_q * NchL) + ADDR_W'(rd_ch);

   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      len_d       = len_q;
      ch_d        = ch_q;
      loop_d      = loop_q;
      stop_pend_d = stop_pend_q;
      m_data_d    = m_data_q;
      m_ch_d      = m_ch_q;
      err_d       = err_q;
      underrun_d  = underrun_q;
      cap_full_d  = cap_full_q;
      cap_count_d = cap_count_q;
      cap_we      = 1'b0;

      // Free-running frame divider while busy; idle holds it at zero.
      if (!busy_int) begin
         div_cnt_d = '0;
      end else if (div_cnt_q == DivLast) begin
         div_cnt_d = '0;
      end else begin
         div_cnt_d = div_cnt_q + 1'b1;
      end

      if (busy_int && stop) begin
         stop_pend_d = 1'b1;
      end
      // A tick outside WAIT_TICK is lost; the pending frame goes out on the next one.
      if (tick && (state_q != StWaitTick)) begin
         underrun_d = 1'b1;
      end
      if (busy_int && s_valid) begin
         if (cap_count_q == CapMax) begin
            cap_full_d = 1'b1;
         end else begin
            cap_we      = 1'b1;
            cap_count_d = cap_count_q + 1'b1;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (len_ok) begin
                  state_d     = StWaitTick;
                  frame_d     = '0;
                  ch_d        = '0;
                  len_d       = {1'b0, len};
                  loop_d      = loop_en;
                  stop_pend_d = 1'b0;
                  err_d       = 1'b0;
                  underrun_d  = 1'b0;
                  cap_full_d  = 1'b0;
                  cap_count_d = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StWaitTick: begin
            if (stop_req) begin
               state_d = StDone;
            end else if (tick) begin
               ch_d    = '0;
               state_d = StFetch;
            end
         end
         StFetch: begin
            if (stop_req) begin
               state_d = StDone;
            end else begin
               m_data_d = pb_rd_q;
               m_ch_d   = ch_q;
               state_d  = StSend;
            end
         end
         StSend: begin
            if (m_ready) begin
               if (ch_q < LastCh) begin
                  ch_d    = ch_q + 3'd1;
                  state_d = StFetch;
               end else begin
                  ch_d    = '0;
                  frame_d = frame_inc;
                  state_d = StWaitTick;
                  if (frame_inc == len_q) begin
                     if (loop_q) begin
                        frame_d = '0;
                     end else begin
                        state_d = StDone;
                     end
                  end
               end
               // Stop only takes effect once the presented word has been transferred.
               if (stop_req) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            stop_pend_d = 1'b0;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         frame_q     <= '0;
         len_q       <= '0;
         ch_q        <= '0;
         loop_q      <= 1'b0;
         stop_pend_q <= 1'b0;
         div_cnt_q   <= '0;
         m_data_q    <= '0;
         m_ch_q      <= '0;
         err_q       <= 1'b0;
         underrun_q  <= 1'b0;
         cap_full_q  <= 1'b0;
         cap_count_q <= '0;
      end else begin
         state_q     <= state_d;
         frame_q     <= frame_d;
         len_q       <= len_d;
         ch_q        <= ch_d;
         loop_q      <= loop_d;
         stop_pend_q <= stop_pend_d;
         div_cnt_q   <= div_cnt_d;
         m_data_q    <= m_data_d;
         m_ch_q      <= m_ch_d;
         err_q       <= err_d;
         underrun_q  <= underrun_d;
         cap_full_q  <= cap_full_d;
         cap_count_q <= cap_count_d;
      end
   end

   // Memories carry no reset.
   always_ff @(posedge clk) begin
      if (wr_en && !busy_int) begin
         pb_mem[wr_addr] <= wr_data;
      end
      pb_rd_q <= pb_mem[pb_raddr];
   end

   always_ff @(posedge clk) begin
      if (cap_we) begin
         cap_mem[cap_count_q[ADDR_W-1:0]] <= s_data;
      end
      rd_data_q <= cap_mem[rd_addr];
   end

   assign m_data    = m_data_q;
   assign m_ch      = m_ch_q;
   assign m_valid   = (state_q == StSend);
   assign rd_data   = rd_data_q;
   assign busy      = busy_int;
   assign done      = (state_q == StDone);
   assign err       = err_q;
   assign underrun  = underrun_q;
   assign cap_full  = cap_full_q;
   assign cap_count = cap_count_q;

endmodule

// File: tb/tb_sample_stream_engine.sv
module tb_sample_stream_engine;

   localparam int DW = 16;
   localparam int NCH = 2;
   localparam int DEP = 16;
   localparam int RDIV = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          loop_en = 1'b0;
   logic [AW-1:0] len = '0;
   logic [DW-1:0] m_data;
   logic [2:0]    m_ch;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] rd_data;
   logic          busy, done, err, underrun, cap_full;
   logic [AW:0]   cap_count;

   logic          lb = 1'b0;
   logic          s_valid_drv = 1'b0;
   logic [DW-1:0] s_data_drv = '0;
   assign s_valid = lb ? (m_valid & m_ready) : s_valid_drv;
   assign s_data  = lb ? m_data : s_data_drv;

   sample_stream_engine #(
      .DATA_W(DW), .N_CH(NCH), .DEPTH(DEP), .RATE_DIV(RDIV)
   ) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .stop(stop), .loop_en(loop_en), .len(len),
      .m_data(m_data), .m_ch(m_ch), .m_valid(m_valid), .m_ready(m_ready),
      .s_data(s_data), .s_valid(s_valid), .rd_addr(rd_addr), .rd_data(rd_data),
      .busy(busy), .done(done), .err(err), .underrun(underrun), .cap_full(cap_full),
      .cap_count(cap_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] data;
      logic [2:0]    ch;
      int            at;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_checks = 0;
   int   n_fail = 0;
   int   xfers = 0;
   int   done_cnt = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: pops the scoreboard on every handshake.
   always @(negedge clk) begin
      if (rst && done) done_cnt++;
      if (rst && m_valid && m_ready) begin
         xfers++;
         if (sb.size() == 0) begin
            chk("unexpected_xfer", 32'(m_data), 32'hffff_ffff);
         end else begin
            e = sb.pop_front();
            chk("xfer_data", 32'(m_data), 32'(e.data));
            chk("xfer_ch", 32'(m_ch), 32'(e.ch));
            if (e.at >= 0) chk("xfer_cycle", 32'(cyc), 32'(e.at));
         end
      end
   end

   // Expected stream for a run started in cycle c; timed entries assume m_ready stays high.
   task automatic push_run(input int c, input int nfr, input int ln, input bit timed);
      exp_t x;
      for (int f = 0; f < nfr; f++) begin
         for (int k = 0; k < NCH; k++) begin
            x.data = DW'(16'h0100 + (f % ln) * NCH + k);
            x.ch   = 3'(k);
            x.at   = timed ? c + 3 + RDIV * f + 2 * k : -1;
            sb.push_back(x);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int ln, input bit lp);
      start = 1'b1;
      len = AW'(ln);
      loop_en = lp;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int max);
      int n = 0;
      while (!done && n < max) begin
         step();
         n++;
      end
      if (!done) chk("done_timeout", 32'd0, 32'd1);
      else chk("busy_at_done", 32'(busy), 32'd0);
   endtask

   task automatic wait_xfers(input int target, input int max);
      int n = 0;
      while (xfers < target && n < max) begin
         step();
         n++;
      end
      if (xfers < target) chk("xfer_timeout", 32'(xfers), 32'(target));
   endtask

   initial begin
      int c, d0;
      repeat (3) step();
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_m_data", 32'(m_data), 0);
      chk("rst_flags", {busy, done, err, underrun, cap_full}, 0);
      chk("rst_cap_count", 32'(cap_count), 0);
      rst = 1'b1;
      step();

      for (int i = 0; i < DEP; i++) begin
         wr_en = 1'b1;
         wr_addr = AW'(i);
         wr_data = DW'(16'h0100 + i);
         step();
      end
      wr_en = 1'b0;

      // One-shot, three frames, timed.
      d0 = done_cnt;
      xfers = 0;
      c = cyc;
      push_run(c, 3, 3, 1'b1);
      do_start(3, 1'b0);
      chk("busy_after_start", 32'(busy), 1);
      wait_done(60);
      step();
      repeat (10) step();
      chk("oneshot_xfers", 32'(xfers), 6);
      chk("oneshot_done_once", 32'(done_cnt - d0), 1);

      // Looping run, stop lands on the 9th transfer's SEND cycle.
      d0 = done_cnt;
      xfers = 0;
      c = cyc;
      push_run(c, 5, 3, 1'b1);
      repeat (NCH) void'(sb.pop_back());
      sb.push_back('{data: 16'h0102, ch: 3'd0, at: c + 3 + RDIV * 4});
      do_start(3, 1'b1);
      wait_xfers(8, 60);
      for (int n = 0; n < 20 && !m_valid; n++) step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      wait_done(10);
      repeat (30) step();
      chk("loop_xfers", 32'(xfers), 9);
      chk("loop_done_once", 32'(done_cnt - d0), 1);
      chk("loop_sb_empty", 32'(sb.size()), 0);

      // Back-pressure on frame 0 ch1 for 20 cycles.
      xfers = 0;
      push_run(cyc, 3, 3, 1'b0);
      do_start(3, 1'b0);
      wait_xfers(1, 20);
      m_ready = 1'b0;
      step();
      for (int n = 0; n < 20; n++) begin
         chk("stall_hold", {m_valid, m_data}, {1'b1, 16'h0101});
         step();
      end
      m_ready = 1'b1;
      wait_done(80);
      chk("stall_xfers", 32'(xfers), 6);
      chk("stall_underrun", 32'(underrun), 1);
      step();

      // Loopback capture of 16 samples, then readback.
      xfers = 0;
      lb = 1'b1;
      push_run(cyc, 8, 8, 1'b1);
      do_start(8, 1'b0);
      chk("underrun_cleared", 32'(underrun), 0);
      wait_done(120);
      step();
      lb = 1'b0;
      chk("lb_cap_count", 32'(cap_count), 16);
      chk("lb_cap_full", 32'(cap_full), 0);
      for (int i = 0; i < DEP; i++) begin
         rd_addr = AW'(i);
         step();
         chk("lb_readback", 32'(rd_data), 32'(16'h0100 + i));
      end

      // Constant s_valid for 40 cycles; start-cycle sample must not be captured.
      xfers = 0;
      c = cyc;
      push_run(c, 5, 8, 1'b1);
      s_valid_drv = 1'b1;
      s_data_drv = 16'ha000;
      do_start(8, 1'b0);
      for (int j = 1; j < 40; j++) begin
         s_data_drv = DW'(16'ha000 + j);
         step();
      end
      s_valid_drv = 1'b0;
      stop = 1'b1;
      step();
      stop = 1'b0;
      wait_done(10);
      step();
      chk("ovf_cap_count", 32'(cap_count), 16);
      chk("ovf_cap_full", 32'(cap_full), 1);
      chk("ovf_xfers", 32'(xfers), 10);
      for (int i = 0; i < DEP; i++) begin
         rd_addr = AW'(i);
         step();
         chk("ovf_readback", 32'(rd_data), 32'(16'ha001 + i));
      end

      // Out-of-range lengths.
      do_start(0, 1'b0);
      chk("len0_err", {err, busy}, 2'b10);
      do_start(9, 1'b0);
      chk("len9_err", {err, busy}, 2'b10);

      // Accepted start clears err; stall in SEND, then reset.
      m_ready = 1'b0;
      do_start(3, 1'b0);
      chk("err_cleared", {err, busy}, 2'b01);
      s_valid_drv = 1'b1;
      for (int n = 0; n < 20 && !m_valid; n++) step();
      s_valid_drv = 1'b0;
      repeat (8) step();
      chk("pre_rst_state", {m_valid, underrun}, 2'b11);
      d0 = done_cnt;
      rst = 1'b0;
      step();
      chk("rst_mid_m_valid", 32'(m_valid), 0);
      chk("rst_mid_flags", {busy, done, err, underrun, cap_full}, 0);
      chk("rst_mid_cap_count", 32'(cap_count), 0);
      rst = 1'b1;
      m_ready = 1'b1;
      repeat (5) step();
      chk("rst_no_done", 32'(done_cnt - d0), 0);
      chk("final_sb_empty", 32'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
